bit_enum: RTL
=============

Name: bit_enum

Overview:
Sequential bit-position enumerator for the ALU bit-manipulation group; the inverse of bit counting.
- Accepts a W-bit word over a valid/ready handshake.
- Emits, one beat per set bit, the index of each set bit, in LSB-first (ctz order) or MSB-first (clz order).
- Used for register-mask expansion (load/store-multiple style) and interrupt-vector walking.

Parameters:
ORDER, 3, log2 of word width; W = 2**ORDER is a localparam, not overridable.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  input word offered.
in_ready  output  1  block can accept a word this cycle.
in  input  W  word to enumerate.
msb  input  1  sampled with in; 1 = MSB-first, 0 = LSB-first.
out_valid  output  1  out/out_last/out_zero are valid.
out_ready  input  1  consumer takes the current beat.
out  output  ORDER  bit index of the current set bit.
out_last  output  1  current beat is the final beat for this word.
out_zero  output  1  accepted word was all-zero (single dummy beat).

Behaviour:
- Internal state:
  - word register r[W-1:0]
  - direction register d
  - state IDLE / RUN
- Reset (asynchronous, any time, including mid-word):
  - state=IDLE, r=0, d=0.
  - out_valid=0, out=0, out_last=0, out_zero=0, in_ready=1.
  - A partially enumerated word is discarded with no further beats.
- Input handshake: transfer when in_valid & in_ready. In the next cycle r=in, d=msb, zero flag = (in==0), state=RUN.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last); it is combinational from state and out_ready.
- Latency: first beat is valid the cycle after acceptance.
- Back-to-back words: when the final beat transfers and a new word is accepted in the same cycle, the new word's first beat is valid the next cycle (no bubble).
- RUN beat contents:
  - out = index of lowest set bit of r when d=0, or of highest set bit when d=1.
  - out_last = 1 when r has exactly one set bit.
  - out_valid = 1 throughout RUN.
- Beat transfer (out_valid & out_ready): the reported bit is cleared in r. If out_last, state goes to IDLE, unless a new word is accepted in the same cycle, in which case state stays RUN with the new word.
- Stall (out_valid & ~out_ready): out, out_last and out_zero hold stable; r is unchanged.
- Zero word:
  - Exactly one beat with out=0, out_zero=1, out_last=1.
  - out_zero=0 on every beat of a non-zero word.
- Beat count per word = popcount(in), or 1 for a zero word.
- Indices within a word are strictly increasing (d=0) or strictly decreasing (d=1).
- in and msb are ignored when no input handshake occurs.
- Index search is combinational over r, as a priority encoder in the chosen direction; there is no multi-cycle search.

Optional Feature:
BIT_ENUM_COUNT_EN
- Defined:
  - Adds output out_count [ORDER:0], the 0-based ordinal of the current beat within its word.
  - out_count resets to 0 on acceptance, increments on each beat transfer, and is 0 on the zero-word beat.
  - Reset value is 0.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. ORDER=3, in=8'b1010_0100, msb=0, out_ready=1 -> beats out=2,5,7; out_last only on 7; out_zero=0; in_ready=1 on the cycle of beat 7.
2. Same word with msb=1 -> beats out=7,5,2, out_last on 2; with BIT_ENUM_COUNT_EN, out_count=0,1,2.
3. in=8'h00 -> exactly one beat: out=0, out_zero=1, out_last=1; block returns to IDLE the next cycle.
4. in=8'hFF, msb=0, out_ready toggled 1,0,1,0,... -> beats 0..7 in order; out is held through every stalled cycle; 8 beats total; in_ready=0 until beat 7 transfers.
5. Word A=8'h81 then word B=8'h10, both presented with in_valid held -> beats 0,7(last),4(last) on consecutive cycles; B is accepted on A's last-beat cycle.
6. in=8'hF0, reset asserted after beat 4 transfers -> out_valid=0 asynchronously; after release, in_ready=1 and no beats 5..7 appear; a new word 8'h02 yields a single beat out=1, out_last=1.

Source files
------------

// File: rtl/bit_enum.sv
// Sequential bit-position enumerator: accepts a W-bit word and emits the index of each set bit,
// LSB-first or MSB-first. Optional macro BIT_ENUM_COUNT_EN adds the per-word beat ordinal out_count.
module bit_enum #(
  parameter int ORDER = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2**ORDER-1:0] in,
  input  logic             msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ORDER-1:0] out,
  output logic             out_last,
  output logic             out_zero
`ifdef BIT_ENUM_COUNT_EN
  ,
  output logic [ORDER:0]   out_count
`endif
);

  localparam int W = 2**ORDER;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     r_q, r_d;
  logic             d_q, d_d;
  logic             zero_q, zero_d;

  logic [ORDER-1:0] lo_idx, hi_idx, sel_idx;
  logic             single, run, fire, accept;

  // Two priority encoders over the remaining bits; direction picks one of them.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lo_idx = '0;
    for (int i = W-1; i >= 0; i--) begin
      if (r_q[i]) lo_idx = ORDER'(i);
    end
    hi_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (r_q[i]) hi_idx = ORDER'(i);
    end
  end

  assign sel_idx   = d_q ? hi_idx : lo_idx;
  assign single    = (r_q != '0) && ((r_q & (r_q - W'(1))) == '0);
  assign run       = (state_q == RUN);

  assign out_valid = run;
  assign out       = (run && !zero_q) ? sel_idx : '0;
  assign out_last  = run && (zero_q || single);
  assign out_zero  = run && zero_q;

  assign fire      = run && out_ready;
  assign in_ready  = !run || (fire && out_last);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    zero_d  = zero_q;
    if (fire) begin
      r_d = r_q & ~(W'(1) << sel_idx);
      if (out_last) begin
        state_d = IDLE;
        zero_d  = 1'b0;
      end
    end
    // A new word accepted on the final beat overrides the return to IDLE: no bubble.
    if (accept) begin
      state_d = RUN;
      r_d     = in;
      d_d     = msb;
      zero_d  = (in == '0);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      d_q     <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      zero_q  <= zero_d;
    end
  end

`ifdef BIT_ENUM_COUNT_EN
  logic [ORDER:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (fire)   count_d = count_q + (ORDER+1)'(1);
    if (accept) count_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign out_count = count_q;
`endif

endmodule
